// File: rtl/sha256_digest_streamer.sv
// sha256_digest_streamer: captures a 256-bit digest on a rising edge of
// digest_done and streams it out big-endian over a valid/ready byte port.
// Optional build macro SHA256_DIGEST_HEX_EN: emit each digest byte as two
// lowercase ASCII hex characters (64 bytes per digest) instead of 32 raw bytes.
// GAP_CYCLES inserts idle cycles (tx_valid low) after every non-final byte.
module sha256_digest_streamer #(
  parameter int GAP_CYCLES = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] digest_in,
  input  logic         digest_done,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         tx_last,
  output logic         busy,
  output logic         overrun
);

`ifdef SHA256_DIGEST_HEX_EN
  localparam int CNT_W = 6;
`else
  localparam int CNT_W = 5;
`endif
  // index of the final output byte: 31 raw, 63 hex
  localparam logic [CNT_W-1:0] LAST_IDX = '1;
  // gap counter counts down to zero, so it is loaded with N-1
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES) - 8'd1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t           r_state;
  logic             r_done_q;
  logic [255:0]     r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_gap_cnt;
  logic [7:0]       r_tx_data;
  logic             r_tx_valid;
  logic             r_tx_last;
  logic             r_busy;
  logic             r_overrun;

  logic             w_rise;
  logic             w_xfer;
  logic [CNT_W-1:0] w_next_cnt;
  logic [255:0]     w_next_shift;
  logic [7:0]       w_next_data;
  logic [255:0]     w_cap_shift;
  logic [7:0]       w_cap_data;

  assign w_rise     = digest_done & ~r_done_q;
  assign w_xfer     = r_tx_valid & tx_ready;
  assign w_next_cnt = r_cnt + 1'b1;

`ifdef SHA256_DIGEST_HEX_EN
  // one nibble to its lowercase ASCII hex character
  function automatic logic [7:0] f_hex(input logic [7:0] b, input logic lo);
    logic [3:0] n;
    n = lo ? b[3:0] : b[7:4];
    return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h57 + {4'd0, n});
  endfunction

  // r_shift keeps the current byte on top; it only moves on after the low
  // nibble (odd count) has gone out
  assign w_next_shift = r_cnt[0] ? {r_shift[247:0], 8'h00} : r_shift;
  assign w_next_data  = f_hex(w_next_shift[255:248], w_next_cnt[0]);
  assign w_cap_shift  = digest_in;
  assign w_cap_data   = f_hex(digest_in[255:248], 1'b0);
`else
  // r_shift holds the bytes still to come after the one in r_tx_data
  assign w_next_shift = {r_shift[247:0], 8'h00};
  assign w_next_data  = r_shift[255:248];
  assign w_cap_shift  = {digest_in[247:0], 8'h00};
  assign w_cap_data   = digest_in[255:248];
`endif

  // capture / send / gap sequencing with registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_done_q   <= 1'b0;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_gap_cnt  <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_tx_last  <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_done_q <= digest_done;
      // an edge that cannot be captured is only flagged; the stream goes on
      if (w_rise && (r_state != S_IDLE)) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_shift    <= w_cap_shift;
            r_cnt      <= '0;
            r_tx_data  <= w_cap_data;
            r_tx_valid <= 1'b1;
            r_tx_last  <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_xfer) begin
            if (r_cnt == LAST_IDX) begin
              r_tx_valid <= 1'b0;
              r_tx_last  <= 1'b0;
              r_busy     <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_shift   <= w_next_shift;
              r_cnt     <= w_next_cnt;
              r_tx_data <= w_next_data;
              if (GAP_CYCLES > 0) begin
                // tx_last stays low while nothing is presented
                r_tx_valid <= 1'b0;
                r_tx_last  <= 1'b0;
                r_gap_cnt  <= GAP_LOAD;
                r_state    <= S_GAP;
              end else begin
                r_tx_last <= (w_next_cnt == LAST_IDX);
              end
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt == 8'd0) begin
            r_tx_valid <= 1'b1;
            r_tx_last  <= (r_cnt == LAST_IDX);
            r_state    <= S_SEND;
          end else begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign tx_last  = r_tx_last;
  assign busy     = r_busy;
  assign overrun  = r_overrun;

endmodule
